// File: rtl/car_movement_pkg.sv
// Shared constants, lane direction type and wrap arithmetic for the car movement block.
package car_movement_pkg;

   localparam int H_DISPLAY_DEF = 640;
   localparam int V_DISPLAY_DEF = 480;
   localparam int CAR_WIDTH     = 64;
   localparam int NUM_LANES     = 6;

   localparam int LANE_PERIOD_DEF [NUM_LANES] = '{4, 3, 2, 4, 3, 2};
   localparam int LANE_X0_DEF     [NUM_LANES] = '{0, 100, 200, 300, 400, 500};

   typedef enum logic {
      DIR_LEFT  = 1'b0,
      DIR_RIGHT = 1'b1
   } dir_t;

   // Steps x by 'step' pixels with wrap-around inside 0..h_max-1 (11-bit headroom).
   function automatic logic [10:0] wrap_step(input logic [10:0] x,
                                             input logic [10:0] step,
                                             input dir_t        dir,
                                             input logic [10:0] h_max);
      logic [10:0] r;
      if (dir == DIR_RIGHT) begin
         r = x + step;
         if (r >= h_max) r = r - h_max;
      end else if (x < step) begin
         r = x + h_max - step;
      end else begin
         r = x - step;
      end
      return r;
   endfunction

endpackage

// File: rtl/lane_mover.sv
// One traffic lane: frame prescaler, fixed direction, wrap arithmetic and position register.
module lane_mover
   import car_movement_pkg::*;
#(
   parameter int   H_DISPLAY = H_DISPLAY_DEF,
   parameter int   PERIOD    = 4,
   parameter int   X0        = 0,
   parameter dir_t DIR       = DIR_LEFT
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       load,
   input  logic       advance,
   input  logic [1:0] level,
   output logic [9:0] x
);

   localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

   logic [CW-1:0] presc;
   logic          wrap;
   logic [10:0]   step;
   logic [10:0]   next_x;

   assign wrap   = (presc == CW'(PERIOD - 1));
   assign step   = {9'd0, level} + 11'd1;
   assign next_x = wrap_step({1'b0, x}, step, DIR, 11'(H_DISPLAY));

   // NOTE: registers use non-blocking assignments so every lane samples the same pre-edge values.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         x     <= 10'(X0);
         presc <= '0;
      end else if (load) begin
         x     <= 10'(X0);
         presc <= '0;
      end else if (advance) begin
         if (wrap) begin
            presc <= '0;
            x     <= next_x[9:0];
         end else begin
            presc <= presc + CW'(1);
         end
      end
   end

endmodule

// File: rtl/car_movement.sv
// Six-lane car position generator: run/freeze FSM, end-of-frame tick, one lane_mover per lane.
module car_movement
   import car_movement_pkg::*;
#(
   parameter int H_DISPLAY     = H_DISPLAY_DEF,
   parameter int V_DISPLAY     = V_DISPLAY_DEF,
   parameter int LANE_PERIOD_1 = LANE_PERIOD_DEF[0],
   parameter int LANE_PERIOD_2 = LANE_PERIOD_DEF[1],
   parameter int LANE_PERIOD_3 = LANE_PERIOD_DEF[2],
   parameter int LANE_PERIOD_4 = LANE_PERIOD_DEF[3],
   parameter int LANE_PERIOD_5 = LANE_PERIOD_DEF[4],
   parameter int LANE_PERIOD_6 = LANE_PERIOD_DEF[5],
   parameter int LANE_X0_1     = LANE_X0_DEF[0],
   parameter int LANE_X0_2     = LANE_X0_DEF[1],
   parameter int LANE_X0_3     = LANE_X0_DEF[2],
   parameter int LANE_X0_4     = LANE_X0_DEF[3],
   parameter int LANE_X0_5     = LANE_X0_DEF[4],
   parameter int LANE_X0_6     = LANE_X0_DEF[5]
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic [9:0] h_count,
   input  logic [9:0] v_count,
   input  logic       start,
   input  logic       freeze,
   input  logic [1:0] level,
   output logic [9:0] car_x1,
   output logic [9:0] car_x2,
   output logic [9:0] car_x3,
   output logic [9:0] car_x4,
   output logic [9:0] car_x5,
   output logic [9:0] car_x6,
   output logic       frame_tick,
   output logic       running
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] RUN    = 2'd1;
   localparam logic [1:0] FROZEN = 2'd2;

   localparam int PERIODS [NUM_LANES] = '{LANE_PERIOD_1, LANE_PERIOD_2, LANE_PERIOD_3,
                                          LANE_PERIOD_4, LANE_PERIOD_5, LANE_PERIOD_6};
   localparam int X0S     [NUM_LANES] = '{LANE_X0_1, LANE_X0_2, LANE_X0_3,
                                          LANE_X0_4, LANE_X0_5, LANE_X0_6};

   logic [1:0] state;
   logic [1:0] state_nxt;
   logic       tick_cond;
   logic       tick_cond_q;
   logic       load;
   logic       advance;
   logic [9:0] lane_x [NUM_LANES];

   assign tick_cond = (h_count == 10'd0) && (v_count == 10'(V_DISPLAY));

   // Frame tick fires on entry into the (0, V_DISPLAY) beam position only.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         // NOTE: reset the history to 1 so a beam parked on the tick position during reset cannot fire a tick.
         tick_cond_q <= 1'b1;
         frame_tick  <= 1'b0;
      end else begin
         tick_cond_q <= tick_cond;
         frame_tick  <= tick_cond & ~tick_cond_q;
      end
   end

   always_comb begin
      // NOTE: default first so every path assigns state_nxt and no latch is inferred.
      state_nxt = state;
      if (freeze && (start || state == RUN)) state_nxt = FROZEN;
      else if (start)                        state_nxt = RUN;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) state <= IDLE;
      else        state <= state_nxt;
   end

   assign load    = start & ~freeze;
   assign advance = (state == RUN) & frame_tick;
   assign running = (state == RUN);

   for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
      lane_mover #(
         .H_DISPLAY (H_DISPLAY),
         .PERIOD    (PERIODS[k]),
         .X0        (X0S[k]),
         .DIR       (dir_t'(k % 2))
      ) u_lane (
         .CLK     (CLK),
         .RST_N   (RST_N),
         .load    (load),
         .advance (advance),
         .level   (level),
         .x       (lane_x[k])
      );
   end

   assign car_x1 = lane_x[0];
   assign car_x2 = lane_x[1];
   assign car_x3 = lane_x[2];
   assign car_x4 = lane_x[3];
   assign car_x5 = lane_x[4];
   assign car_x6 = lane_x[5];

endmodule

// File: tb/tb_car_movement.sv
// Scoreboard bench for car_movement: expected lane positions are queued per frame and popped on compare.
module tb_car_movement;

   localparam int PER [6] = '{4, 3, 2, 4, 3, 2};
   localparam int X0  [6] = '{0, 100, 200, 300, 400, 500};
   localparam int HD  = 640;

   logic       CLK = 1'b0;
   logic       RST_N;
   logic [9:0] h_count, v_count;
   logic       start, freeze;
   logic [1:0] level;
   logic [9:0] car_x1, car_x2, car_x3, car_x4, car_x5, car_x6;
   logic       frame_tick, running;

   int         checks = 0;
   int         errors = 0;
   int         mx   [6];
   int         mcnt [6];
   bit         mrun;
   logic [9:0] exp_q [$];

   always #5 CLK = ~CLK;

   car_movement dut (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .h_count    (h_count),
      .v_count    (v_count),
      .start      (start),
      .freeze     (freeze),
      .level      (level),
      .car_x1     (car_x1),
      .car_x2     (car_x2),
      .car_x3     (car_x3),
      .car_x4     (car_x4),
      .car_x5     (car_x5),
      .car_x6     (car_x6),
      .frame_tick (frame_tick),
      .running    (running)
   );

   function automatic logic [9:0] dut_x(input int k);
      case (k)
         0:       return car_x1;
         1:       return car_x2;
         2:       return car_x3;
         3:       return car_x4;
         4:       return car_x5;
         default: return car_x6;
      endcase
   endfunction

   task automatic model_reload();
      for (int k = 0; k < 6; k++) begin
         mx[k]   = X0[k];
         mcnt[k] = 0;
      end
   endtask

   task automatic model_frame(input int lvl);
      if (mrun) begin
         for (int k = 0; k < 6; k++) begin
            mcnt[k]++;
            if (mcnt[k] == PER[k]) begin
               mcnt[k] = 0;
               if (k % 2 == 0) mx[k] = (mx[k] - (lvl + 1) + HD) % HD;
               else            mx[k] = (mx[k] + lvl + 1) % HD;
            end
         end
      end
   endtask

   task automatic push_expected();
      for (int k = 0; k < 6; k++) exp_q.push_back(10'(mx[k]));
   endtask

   task automatic compare_positions(input string tag);
      logic [9:0] e;
      for (int k = 0; k < 6; k++) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s car_x%0d: scoreboard empty", tag, k + 1);
         end else begin
            e = exp_q.pop_front();
            if (dut_x(k) !== e) begin
               errors++;
               $display("FAIL %s car_x%0d: got %0d expected %0d", tag, k + 1, dut_x(k), e);
            end
         end
      end
   endtask

   task automatic cycle();
      @(posedge CLK);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      cycle();
      start = 1'b0;
   endtask

   // One frame boundary: beam enters (0,480), tick appears, lanes update on the following edge.
   task automatic do_frame(input string tag);
      h_count = 10'd0;
      v_count = 10'd480;
      cycle();
      h_count = 10'd1;
      checks++;
      if (frame_tick !== 1'b1) begin
         errors++;
         $display("FAIL %s frame_tick: got %b expected 1", tag, frame_tick);
      end
      cycle();
      model_frame(int'(level));
      push_expected();
      compare_positions(tag);
   endtask

   task automatic test_reset();
      RST_N   = 1'b0;
      h_count = 10'd0;
      v_count = 10'd480;
      start   = 1'b0;
      freeze  = 1'b0;
      level   = 2'd0;
      mrun    = 1'b0;
      #12;
      model_reload();
      push_expected();
      compare_positions("reset_pos");
      checks++;
      if (running !== 1'b0 || frame_tick !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags: running=%b frame_tick=%b expected 0 0", running, frame_tick);
      end
      @(negedge CLK);
      RST_N = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cycle();
         checks++;
         if (frame_tick !== 1'b0) begin
            errors++;
            $display("FAIL no_spurious_tick cycle %0d: got %b expected 0", i, frame_tick);
         end
      end
      h_count = 10'd1;
      cycle();
   endtask

   task automatic test_level0_motion();
      level = 2'd0;
      pulse_start();
      model_reload();
      mrun = 1'b1;
      checks++;
      if (running !== 1'b1) begin
         errors++;
         $display("FAIL run_after_start: running=%b expected 1", running);
      end
      for (int f = 0; f < 4; f++) do_frame("level0");
      checks++;
      if (car_x1 !== 10'd639 || car_x2 !== 10'd101) begin
         errors++;
         $display("FAIL level0_wrap: car_x1=%0d car_x2=%0d expected 639 101", car_x1, car_x2);
      end
   endtask

   task automatic test_right_wrap();
      int guard = 0;
      while (mx[3] != 638 && guard < 2000) begin
         level = (638 - mx[3] >= 4) ? 2'd3 : 2'd0;
         do_frame("approach");
         guard++;
      end
      checks++;
      if (guard >= 2000) begin
         errors++;
         $display("FAIL approach_timeout: model x4=%0d expected 638", mx[3]);
      end
      level = 2'd3;
      for (int f = 0; f < 4; f++) do_frame("right_wrap");
      checks++;
      if (car_x4 !== 10'd2) begin
         errors++;
         $display("FAIL right_wrap_x4: got %0d expected 2", car_x4);
      end
   endtask

   task automatic test_freeze();
      freeze = 1'b1;
      cycle();
      mrun = 1'b0;
      checks++;
      if (running !== 1'b0) begin
         errors++;
         $display("FAIL freeze_running: got %b expected 0", running);
      end
      for (int f = 0; f < 10; f++) do_frame("frozen");
      freeze = 1'b0;
      cycle();
      checks++;
      if (running !== 1'b0) begin
         errors++;
         $display("FAIL unfreeze_no_start: running=%b expected 0", running);
      end
      pulse_start();
      model_reload();
      mrun = 1'b1;
      push_expected();
      compare_positions("restart_reload");
      checks++;
      if (running !== 1'b1) begin
         errors++;
         $display("FAIL restart_running: got %b expected 1", running);
      end
   endtask

   task automatic test_start_freeze_idle();
      @(negedge CLK);
      RST_N = 1'b0;
      #2;
      RST_N = 1'b1;
      model_reload();
      mrun   = 1'b0;
      level  = 2'd1;
      start  = 1'b1;
      freeze = 1'b1;
      cycle();
      start = 1'b0;
      checks++;
      if (running !== 1'b0) begin
         errors++;
         $display("FAIL start_freeze_running: got %b expected 0", running);
      end
      for (int f = 0; f < 5; f++) do_frame("start_freeze");
      freeze = 1'b0;
      do_frame("frozen_no_start");
      checks++;
      if (running !== 1'b0) begin
         errors++;
         $display("FAIL frozen_stays: running=%b expected 0", running);
      end
   endtask

   task automatic test_frame_sweep();
      int hl [6] = '{0, 1, 2, 639, 640, 799};
      int pulses = 0;
      bit prev_tick = 1'b0;
      for (int f = 0; f < 2; f++) begin
         for (int v = 0; v < 525; v++) begin
            for (int hi = 0; hi < 6; hi++) begin
               h_count = 10'(hl[hi]);
               v_count = 10'(v);
               cycle();
               if (frame_tick === 1'b1) begin
                  pulses++;
                  checks++;
                  if (prev_tick || h_count !== 10'd0 || v_count !== 10'd480) begin
                     errors++;
                     $display("FAIL sweep_pulse: tick after h=%0d v=%0d wide=%b expected after 0,480 width 1",
                              h_count, v_count, prev_tick);
                  end
               end else if (h_count === 10'd0 && v_count === 10'd480) begin
                  checks++;
                  errors++;
                  $display("FAIL sweep_missing: no tick after 0,480 in frame %0d", f);
               end
               prev_tick = (frame_tick === 1'b1);
            end
         end
      end
      checks++;
      if (pulses != 2) begin
         errors++;
         $display("FAIL sweep_count: got %0d pulses expected 2", pulses);
      end
      h_count = 10'd1;
      v_count = 10'd480;
      cycle();
   endtask

   task automatic test_async_reset();
      pulse_start();
      model_reload();
      mrun  = 1'b1;
      level = 2'd2;
      for (int f = 0; f < 5; f++) do_frame("pre_reset");
      h_count = 10'd0;
      v_count = 10'd480;
      cycle();
      h_count = 10'd1;
      #2;
      RST_N = 1'b0;
      #1;
      model_reload();
      mrun = 1'b0;
      push_expected();
      compare_positions("async_reset");
      checks++;
      if (running !== 1'b0 || frame_tick !== 1'b0) begin
         errors++;
         $display("FAIL async_reset_flags: running=%b frame_tick=%b expected 0 0", running, frame_tick);
      end
      cycle();
      cycle();
      @(negedge CLK);
      RST_N = 1'b1;
      cycle();
      push_expected();
      compare_positions("post_reset_hold");
      level = 2'd0;
      pulse_start();
      mrun = 1'b1;
      for (int f = 0; f < 4; f++) do_frame("post_reset_run");
      checks++;
      if (car_x1 !== 10'd639) begin
         errors++;
         $display("FAIL post_reset_first_move: car_x1=%0d expected 639", car_x1);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_level0_motion();
      test_right_wrap();
      test_freeze();
      test_start_freeze_idle();
      test_frame_sweep();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/car_movement.md
CAR_MOVEMENT -- requirements
Module: car_movement

Interface
REQ-001 The block SHALL have parameter H_DISPLAY, default 640, visible pixels per line.
REQ-002 The block SHALL have parameter V_DISPLAY, default 480, visible lines per frame.
REQ-003 The block SHALL have parameter LANE_PERIOD_k (k=1..6), defaults 4,3,2,4,3,2, frames between moves of lane k.
REQ-004 The block SHALL have parameter LANE_X0_k (k=1..6), defaults 0,100,200,300,400,500, reset/restart x of car k.
REQ-005 Ports SHALL be: CLK  in  1  system clock (the only clock).
REQ-006 Ports SHALL be: RST_N  in  1  asynchronous, active-low reset.
REQ-007 Ports SHALL be: h_count, v_count  in  10 each  current VGA beam position.
REQ-008 Ports SHALL be: start  in  1  one-cycle pulse: reload start positions and run.
REQ-009 Ports SHALL be: freeze  in  1  level: stop motion (collision/pause).
REQ-010 Ports SHALL be: level  in  2  difficulty 0..3.
REQ-011 Ports SHALL be: car_x1..car_x6  out  10 each  registered car left-edge x, consumed by color_generation.
REQ-012 Ports SHALL be: frame_tick  out  1  one-cycle pulse at frame end.
REQ-013 Ports SHALL be: running  out  1  high in RUN state.

Function
REQ-014 frame_tick SHALL pulse for exactly one CLK cycle on the first cycle where h_count==0 and v_count==V_DISPLAY, once per frame, registered (1-cycle latency).
REQ-015 The FSM SHALL have states IDLE, RUN, FROZEN; reset enters IDLE.
REQ-016 IDLE->RUN on start; RUN->FROZEN when freeze==1; FROZEN->RUN when freeze==0 and start==1; any state with start==1 and freeze==0 reloads all car_x to LANE_X0_k and clears prescalers.
REQ-017 start and freeze high in the same cycle: freeze wins, state becomes/stays FROZEN, positions unchanged.
REQ-018 Positions and prescalers SHALL only change in RUN on a cycle where frame_tick==1.
REQ-019 Per lane, a prescaler SHALL count frame_ticks 0..LANE_PERIOD_k-1; the car moves on the tick where the count wraps to 0.
REQ-020 step SHALL be level+1 pixels (1..4), level sampled on the moving tick.
REQ-021 Odd lanes (1,3,5) SHALL move left (x-step); even lanes (2,4,6) SHALL move right (x+step).
REQ-022 Arithmetic SHALL be 11-bit unsigned; right wrap: if x+step >= H_DISPLAY then x = x+step-H_DISPLAY.
REQ-023 Left wrap: if x < step then x = x+H_DISPLAY-step.
REQ-024 car_x outputs SHALL always lie in 0..H_DISPLAY-1.
REQ-025 Motion SHALL occur only during vertical blank (guaranteed by REQ-014), so color_generation never sees a mid-frame position change.
REQ-026 running SHALL equal (state==RUN).

Reset
REQ-027 RST_N low SHALL asynchronously force: state IDLE, car_xk=LANE_X0_k, prescalers 0, frame_tick 0, running 0.
REQ-028 Reset asserted mid-frame or mid-move SHALL discard any pending move; first motion after release needs start plus a full LANE_PERIOD_k ticks.
REQ-029 Reset release SHALL be followed by no spurious frame_tick unless h_count/v_count actually transition into the tick condition.

Structure
REQ-030 H_DISPLAY, V_DISPLAY, CAR_WIDTH and lane start/period constants SHALL live in constants.v.
REQ-031 One sub-module lane_mover (prescaler, direction, wrap arithmetic, position register) SHALL be instantiated six times; FSM and frame_tick stay in car_movement.

Verification
REQ-032 Reset, then start, level=0, 4 frames -> car_x1: 0 -> 639 after tick 4 (left wrap); car_x2: 100 -> 101 after tick 3.
REQ-033 level=3, car_x4 at 638, LANE_PERIOD_4 ticks -> car_x4 = 2 (right wrap, 638+4-640).
REQ-034 freeze high for 10 frames in RUN -> all car_x constant, running=0; freeze low + start -> positions reload to 0,100,200,300,400,500.
REQ-035 start and freeze same cycle in IDLE -> state FROZEN, positions unchanged, running=0.
REQ-036 Sweep h_count/v_count through 2 full frames -> exactly 2 frame_tick pulses, each 1 cycle wide, 1 cycle after (0,480).
REQ-037 Assert RST_N low mid-frame during RUN -> outputs at reset values immediately (no CLK edge needed).
